// File: rtl/idu_pipe.sv
// idu_pipe: registered RISC-V instruction decode stage (fetch -> execute).
// Decodes one instruction per cycle and holds the results in a two-entry skid
// buffer. Input and output can each stall on their own with no throughput loss.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   flush       synchronous discard of all buffered entries
//   in_valid / in_ready / in_inst / in_pc        fetch-side handshake and beat
//   out_valid / out_ready                         execute-side handshake
//   out_pc, out_type, out_rs1, out_rs2, out_rd,
//   out_funct3, out_imm, out_illegal              decoded beat (main entry)
// Build option:
//   IDU_ILLEGAL_EN  when defined, out_illegal flags N-type opcodes and R-type
//                   words with an unsupported funct7; otherwise it is tied to 0.
module idu_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_type,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned REG_W  = 5;

  localparam logic [TYPE_W-1:0] TYPE_R = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_I = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_S = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_B = 3'b011;
  localparam logic [TYPE_W-1:0] TYPE_U = 3'b100;
  localparam logic [TYPE_W-1:0] TYPE_J = 3'b101;
  localparam logic [TYPE_W-1:0] TYPE_N = 3'b110;

  // One buffered, fully decoded beat
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [TYPE_W-1:0] itype;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{
    pc: '0, itype: TYPE_N, rs1: '0, rs2: '0, rd: '0,
    funct3: '0, imm: '0, illegal: 1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;
  logic   accept;
  logic   issue;
  logic   load_main;
  logic   load_skid;
  logic   main_from_skid;

  // Input-side decode of the offered instruction word
  always_comb begin
    dec        = ENTRY_RST;
    dec.pc     = in_pc;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.funct3 = in_inst[14:12];
    dec.itype  = TYPE_N;

    unique case (in_inst[6:0])
      7'b0110011:                                     dec.itype = TYPE_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.itype = TYPE_I;
      7'b0100011:                                     dec.itype = TYPE_S;
      7'b1100011:                                     dec.itype = TYPE_B;
      7'b0110111, 7'b0010111:                         dec.itype = TYPE_U;
      7'b1101111:                                     dec.itype = TYPE_J;
      // RV64 word-op opcodes; left as N on a 32-bit datapath
      7'b0111011: if (XLEN == 64) dec.itype = TYPE_R;
      7'b0011011: if (XLEN == 64) dec.itype = TYPE_I;
      default:    dec.itype = TYPE_N;
    endcase

    unique case (dec.itype)
      TYPE_I:  dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      TYPE_S:  dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      TYPE_B:  dec.imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      TYPE_U:  dec.imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
      TYPE_J:  dec.imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      default: dec.imm = '0;
    endcase

`ifdef IDU_ILLEGAL_EN
    dec.illegal = (dec.itype == TYPE_N) ||
                  ((dec.itype == TYPE_R) &&
                   (in_inst[31:25] != 7'b0000000) &&
                   (in_inst[31:25] != 7'b0100000));
`else
    dec.illegal = 1'b0;
`endif
  end

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  // Occupancy next-state and entry load controls; flush overrides everything
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = ST_TWO;
            load_skid = 1'b1;
          end else if (issue) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (issue) begin
            state_nxt      = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and buffer entries; flags track the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= ENTRY_RST;
      skid_q    <= ENTRY_RST;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_TWO);
      if (load_main) begin
        main_q <= dec;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_pc      = main_q.pc;
  assign out_type    = main_q.itype;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_funct3  = main_q.funct3;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/idu_pipe.md
# idu_pipe

Registered RISC-V instruction decode stage for the NPC core, placed between instruction fetch and execute. Accepts one 32-bit instruction word plus PC per cycle over a valid/ready handshake. Decodes instruction type, register indices, funct3 and an XLEN-wide sign-extended immediate. Results go through a two-entry skid buffer, so input and output can each stall independently with no throughput loss and no bubbles.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction beat offered.
- in_ready  out  1  stage can accept a beat.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  decoded beat available.
- out_ready  in  1  consumer accepts beat.
- out_pc  out  XLEN  PC passed through.
- out_type  out  3  R=000, I=001, S=010, B=011, U=100, J=101, N=110.
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- out_funct3  out  3  inst[14:12].
- out_imm  out  XLEN  decoded immediate.
- out_illegal  out  1  illegal-instruction flag; see Configuration.

## Operation
- Opcode (inst[6:0]) to type:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - XLEN=64 only: 0111011 → R and 0011011 → I. With XLEN=32 these two opcodes decode as N.
  - Any other opcode → N.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and N types: immediate is 0.
- Register indices and funct3 are extracted unconditionally, whatever the type.
- Decode is combinational on the input side. Decoded fields are stored in the buffer entry, never re-decoded.
- Buffer has a main entry, which drives the out_* ports, and a skid entry. Occupancy state is EMPTY, ONE or TWO.
- Accept = in_valid & in_ready. Issue = out_valid & out_ready.
- State transitions:
  - EMPTY: accept → ONE, main loaded.
  - ONE: accept and issue → ONE, main replaced. Accept only → TWO, skid loaded. Issue only → EMPTY.
  - TWO: no accept possible. Issue → ONE, main ← skid.
- out_valid = (state != EMPTY). in_ready = (state != TWO); it is driven straight from the state register, with no combinational path from out_ready.
- flush has priority over everything. Next state is EMPTY and any beat accepted in the same cycle is dropped. in_ready is not gated by flush.
- Order is preserved: beats issue in exactly the order they were accepted.

## Timing
- Latency: a beat accepted at edge N is on out_* with out_valid=1 after edge N. Total latency is 1 cycle.
- Throughput: 1 beat per cycle while out_ready=1.
- With out_ready=0, exactly two beats are absorbed; in_ready falls the cycle after the second accept.
- out_* stay stable while out_valid=1 and out_ready=0.
- While rst is low, and the first cycle after release:
  - state = EMPTY, out_valid=0, in_ready=1.
  - out_pc, out_imm, out_rs1, out_rs2, out_rd and out_funct3 = 0.
  - out_type = 110, out_illegal = 0.
- Reset asserted mid-operation clears both entries immediately, asynchronously. Beats in flight are lost.

## Configuration
- Macro IDU_ILLEGAL_EN defined: out_illegal is registered with the beat and set when:
  - the type is N; or
  - the type is R and inst[31:25] is neither 0000000 nor 0100000.
- IDU_ILLEGAL_EN undefined: out_illegal is constant 0. Type decoding is unchanged, including N.

## Test plan
- XLEN=32, addi 0xFFF00093 → one cycle later: out_type=001, rd=1, rs1=0, out_imm=0xFFFFFFFF.
- XLEN=32, in sequence:
  - lui 0x123452B7 → type 100, rd=5, imm=0x12345000.
  - jal 0xFFDFF0EF → type 101, rd=1, imm=0xFFFFFFFC.
  - beq 0xFE208CE3 → type 011, rs1=1, rs2=2, imm=0xFFFFFFF8.
- Hold out_ready=0 and offer 3 beats (PC 0x0, 0x4, 0x8):
  - first two accepted, then in_ready=0.
  - raise out_ready → PCs issue in order 0x0, 0x4, 0x8, then back-to-back once all three are accepted.
- addiw 0xFFF0809B:
  - XLEN=64 → type 001, imm=0xFFFFFFFFFFFFFFFF.
  - XLEN=32 → type 110, imm=0.
- In state TWO, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed beat never appears. Also pulse rst low mid-stream → outputs take reset values immediately.
- With IDU_ILLEGAL_EN: 0x00000000 → illegal=1, type 110; 0x02208033 (mul) → illegal=1. Without the macro: both give illegal=0.
